// File: rtl/team_03_wb_responder.sv
// Wishbone classic-cycle responder backed by a byte-writable 32-bit register memory.
// Each accepted request is held for WAIT_STATES cycles, then acknowledged for exactly one cycle.
module team_03_wb_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic [15:0] access_cnt_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is cyc_i & stb_i sampled in IDLE; ack_o is a one-cycle
  // registered pulse; dat_o is non-zero only while ack_o is high; dropping cyc_i
  // before the ack cancels the request with no side effects.

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_wcnt;
  logic [AW-1:0] r_idx;
  logic          r_hit;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_wdat;
  logic          r_ack;
  logic [31:0]   r_dat;
  logic [15:0]   r_acc_cnt;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [29:0]   w_word;
  logic          w_hit;
  logic          w_req;
  logic          w_fire;
  logic          w_live;
  logic [AW-1:0] w_a_idx;
  logic          w_a_hit;
  logic          w_a_we;
  logic [3:0]    w_a_sel;
  logic [31:0]   w_a_dat;

  // BASE_ADDR is word aligned, so the word offset is a 30-bit subtraction.
  assign w_word = adr_i[31:2] - 30'(BASE_ADDR >> 2);
  assign w_hit  = (adr_i >= BASE_ADDR) && (w_word < 30'(DEPTH_WORDS));
  assign w_req  = cyc_i & stb_i;

  assign w_live = (r_state == S_IDLE);
  assign w_fire = (w_live && w_req && (WAIT_STATES == 0)) ||
                  ((r_state == S_WAIT) && cyc_i && (r_wcnt == 4'd1));

  // With zero wait states the ack is issued straight from the live request.
  assign w_a_idx = w_live ? w_word[AW-1:0] : r_idx;
  assign w_a_hit = w_live ? w_hit  : r_hit;
  assign w_a_we  = w_live ? we_i   : r_we;
  assign w_a_sel = w_live ? sel_i  : r_sel;
  assign w_a_dat = w_live ? dat_i  : r_wdat;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_wdat    <= '0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_acc_cnt <= '0;
    end else begin
      r_ack     <= w_fire;
      r_acc_cnt <= r_acc_cnt + {15'd0, w_fire};
      r_dat     <= (w_fire && w_a_hit && !w_a_we) ? r_mem[w_a_idx] : 32'd0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx   <= w_word[AW-1:0];
            r_hit   <= w_hit;
            r_we    <= we_i;
            r_sel   <= sel_i;
            r_wdat  <= dat_i;
            r_wcnt  <= 4'(WAIT_STATES);
            r_state <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt - 4'd1;
          if (!cyc_i) begin
            r_state <= S_IDLE;
          end else if (r_wcnt == 4'd1) begin
            r_state <= S_ACK;
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_fire && w_a_hit && w_a_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_a_sel[b]) begin
          r_mem[w_a_idx][8*b +: 8] <= w_a_dat[8*b +: 8];
        end
      end
    end
  end

  assign dat_o        = r_dat;
  assign ack_o        = r_ack;
  assign busy_o       = (r_state != S_IDLE);
  assign access_cnt_o = r_acc_cnt;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_team_03_wb_responder.sv
// Directed bench for team_03_wb_responder: one instance with two wait states,
// one with zero wait states for back-to-back spacing.
module tb_team_03_wb_responder;

  localparam logic [31:0] BASE = 32'h3300_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cyc0, stb0, we0;
  logic [3:0]  sel0;
  logic [31:0] adr0, wd0, rd0;
  logic        ack0, busy0;
  logic [15:0] cnt0;
  logic [1:0]  st0;

  logic        cyc1, stb1, we1;
  logic [3:0]  sel1;
  logic [31:0] adr1, wd1, rd1;
  logic        ack1, busy1;
  logic [15:0] cnt1;
  logic [1:0]  st1;

  team_03_wb_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(64), .WAIT_STATES(2)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cyc_i(cyc0), .stb_i(stb0), .we_i(we0),
    .sel_i(sel0), .adr_i(adr0), .dat_i(wd0), .dat_o(rd0), .ack_o(ack0),
    .busy_o(busy0), .access_cnt_o(cnt0), .dbg_state_o(st0)
  );

  team_03_wb_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(64), .WAIT_STATES(0)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cyc_i(cyc1), .stb_i(stb1), .we_i(we1),
    .sel_i(sel1), .adr_i(adr1), .dat_i(wd1), .dat_o(rd1), .ack_o(ack1),
    .busy_o(busy1), .access_cnt_o(cnt1), .dbg_state_o(st1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drivers: called at a negedge with the DUT idle; return read data and
  // the number of negedges from drive to the first ack sample (0 = timeout).
  task automatic xfer0(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    cyc0 = 1'b1; stb0 = 1'b1; we0 = we; adr0 = adr; wd0 = dat; sel0 = sel;
    lat = 0; rdata = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack0) begin
        lat = i;
        rdata = rd0;
        break;
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0;
    if (lat == 0) check("dut0_ack_timeout", 32'(ack0), 32'd1);
    @(negedge clk);
  endtask

  task automatic xfer1(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    cyc1 = 1'b1; stb1 = 1'b1; we1 = we; adr1 = adr; wd1 = dat; sel1 = sel;
    lat = 0; rdata = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack1) begin
        lat = i;
        rdata = rd1;
        break;
      end
    end
    cyc1 = 1'b0; stb1 = 1'b0; we1 = 1'b0;
    if (lat == 0) check("dut1_ack_timeout", 32'(ack1), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          nack;
    logic [15:0] exp_cnt0;

    rst = 1'b1;
    cyc0 = 0; stb0 = 0; we0 = 0; sel0 = 0; adr0 = 0; wd0 = 0;
    cyc1 = 0; stb1 = 0; we1 = 0; sel1 = 0; adr1 = 0; wd1 = 0;
    exp_cnt0 = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_ack", 32'(ack0), 32'd0);
    check("reset_dat", rd0, 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_cnt", 32'(cnt0), 32'd0);
    check("reset_cnt1", 32'(cnt1), 32'd0);

    // Write then read with two wait states; ack lands 3 cycles after drive.
    xfer0(1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, rd, lat); exp_cnt0++;
    check("wr_latency", 32'(lat), 32'd3);
    cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b0; adr0 = BASE + 32'h10; sel0 = 4'hF;
    @(negedge clk);
    check("busy_in_wait", 32'(busy0), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rd_ack", 32'(ack0), 32'd1);
    check("rd_data", rd0, 32'hCAFE_F00D);
    check("busy_in_ack", 32'(busy0), 32'd1);
    exp_cnt0++;
    cyc0 = 1'b0; stb0 = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", 32'(ack0), 32'd0);
    check("dat_zero_no_ack", rd0, 32'd0);
    check("cnt_after_two", 32'(cnt0), 32'(exp_cnt0));

    // Low address bits and sel do not affect a read.
    xfer0(1'b0, BASE + 32'h13, 32'h0, 4'h1, rd, lat); exp_cnt0++;
    check("rd_unaligned_fullword", rd, 32'hCAFE_F00D);

    // Byte lanes.
    xfer0(1'b1, BASE + 32'h4, 32'h1122_3344, 4'hF, rd, lat); exp_cnt0++;
    xfer0(1'b1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, rd, lat); exp_cnt0++;
    xfer0(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("byte_lanes", rd, 32'h11BB_33DD);

    // Misses above and below the window: acked, dropped, read as zero.
    xfer0(1'b1, BASE + 32'h100, 32'hDEAD_BEEF, 4'hF, rd, lat); exp_cnt0++;
    check("miss_wr_latency", 32'(lat), 32'd3);
    xfer0(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("miss_rd_data", rd, 32'd0);
    xfer0(1'b0, BASE, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("miss_no_alias_w0", rd, 32'd0);
    xfer0(1'b1, BASE - 32'h4, 32'h1234_5678, 4'hF, rd, lat); exp_cnt0++;
    xfer0(1'b0, BASE + 32'hFC, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("below_base_no_alias", rd, 32'd0);
    check("cnt_after_misses", 32'(cnt0), 32'(exp_cnt0));

    // Abort: drop cyc one cycle after acceptance.
    cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b1; adr0 = BASE + 32'h8; wd0 = 32'h7777_7777; sel0 = 4'hF;
    @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack0) nack++;
    end
    check("abort_no_ack", 32'(nack), 32'd0);
    check("abort_cnt", 32'(cnt0), 32'(exp_cnt0));
    check("abort_idle", 32'(busy0), 32'd0);
    xfer0(1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("abort_no_write", rd, 32'd0);

    // Counter wrap: preload the counter next to its limit.
    dut0.r_acc_cnt = 16'hFFFE;
    exp_cnt0 = 16'hFFFE;
    xfer0(1'b0, BASE, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("cnt_ffff", 32'(cnt0), 32'h0000_FFFF);
    xfer0(1'b0, BASE, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("cnt_wrap", 32'(cnt0), 32'(exp_cnt0));
    check("cnt_wrap_zero", 32'(cnt0), 32'd0);
    xfer0(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat); exp_cnt0++;

    // Zero wait states: single write, then stb held for three reads.
    xfer1(1'b1, BASE, 32'h0BAD_F00D, 4'hF, rd, lat);
    check("ws0_latency", 32'(lat), 32'd1);
    cyc1 = 1'b1; stb1 = 1'b1; we1 = 1'b0; adr1 = BASE; sel1 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ((i % 2) == 0) begin
        check("b2b_ack_high", 32'(ack1), 32'd1);
        check("b2b_data", rd1, 32'h0BAD_F00D);
      end else begin
        check("b2b_ack_gap", 32'(ack1), 32'd0);
        check("b2b_data_gap", rd1, 32'd0);
      end
    end
    cyc1 = 1'b0; stb1 = 1'b0;
    @(negedge clk);
    check("b2b_end_no_ack", 32'(ack1), 32'd0);
    check("b2b_cnt", 32'(cnt1), 32'd4);

    // Asynchronous reset in the middle of WAIT, away from the clock edge.
    cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b1; adr0 = BASE + 32'h20; wd0 = 32'h5555_5555; sel0 = 4'hF;
    @(negedge clk);
    check("pre_reset_busy", 32'(busy0), 32'd1);
    check("pre_reset_cnt", 32'(cnt0), 32'(exp_cnt0));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ack", 32'(ack0), 32'd0);
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_cnt", 32'(cnt0), 32'd0);
    check("async_rst_cnt1", 32'(cnt1), 32'd0);
    cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt0 = 16'd0;
    @(negedge clk);
    xfer0(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("post_rst_mem10", rd, 32'd0);
    xfer0(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("post_rst_mem4", rd, 32'd0);
    xfer0(1'b0, BASE + 32'h20, 32'h0, 4'hF, rd, lat); exp_cnt0++;
    check("post_rst_lost_write", rd, 32'd0);
    check("post_rst_cnt", 32'(cnt0), 32'(exp_cnt0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/team_03_wb_responder.md
Name: team_03_wb_responder

Overview:
- Wishbone classic-cycle responder (slave) for the team_03 master port.
- The master's ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O drive this block's inputs; this block's dat_o/ack_o return on DAT_I/ACK_I.
- Contains a byte-writable 32-bit register memory with a programmable number of wait states.
- Provides the on-chip target the team's master logic reads and writes, and the bench endpoint for that master.

Parameters:
- BASE_ADDR, 32'h3300_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 64, number of 32-bit words; power of two, 2..256.
- WAIT_STATES, 2, idle cycles inserted between request acceptance and ack; 0..15.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe.
- we_i  in  1  1 = write, 0 = read.
- sel_i  in  4  byte lane enables; bit n selects dat bits [8n+7:8n].
- adr_i  in  32  byte address.
- dat_i  in  32  write data.
- dat_o  out  32  read data; valid only while ack_o = 1.
- ack_o  out  1  single-cycle acknowledge.
- busy_o  out  1  high while in WAIT or ACK.
- access_cnt_o  out  16  count of acknowledged transfers; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (async assert, sync release): state = IDLE; ack_o = 0; dat_o = 0; busy_o = 0; access_cnt_o = 0; all memory words = 0.
- Decode:
  - offset = adr_i - BASE_ADDR; hit = (adr_i >= BASE_ADDR) and (offset[31:2] < DEPTH_WORDS).
  - Word index = offset[2+log2(DEPTH_WORDS)-1:2]; adr_i[1:0] is ignored.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If cyc_i & stb_i: latch adr_i, dat_i, sel_i, we_i and hit; load cnt = WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else go directly to ACK.
- WAIT:
  - cnt decrements each cycle; go to ACK on the cycle cnt reaches 1.
  - If cyc_i drops in WAIT: return to IDLE; no write, no ack, counter unchanged.
- ACK:
  - ack_o = 1 for exactly one cycle, then IDLE.
  - Write & hit: update only the bytes whose latched sel bit is 1, in the ACK cycle.
  - Read & hit: dat_o = stored word (all 32 bits regardless of sel).
  - Miss: still acks; writes are dropped; reads return 32'h0000_0000.
  - access_cnt_o increments by 1 in the ACK cycle.
- Latency: request accepted at edge N; ack_o high during cycle N+1+WAIT_STATES.
- Timing is computed from the latched request; inputs after acceptance are ignored except cyc_i (abort).
- dat_o returns to 0 whenever ack_o = 0.
- Back-to-back transfers: a master holding stb_i high after ack is treated as a new request. It is sampled in the IDLE cycle after ACK, so the minimum spacing is 2 + WAIT_STATES cycles per transfer. ack_o is never high in two consecutive cycles.
- Read-after-write to the same word returns the new data.
- Reset mid-transfer: immediate return to IDLE, ack_o = 0, memory cleared; any pending write is lost.

Test Plan:
- Write then read, WAIT_STATES = 2: write 32'hCAFE_F00D to BASE+0x10 with sel = 4'hF -> ack_o high exactly 3 cycles after acceptance. Read of BASE+0x10 -> dat_o = 32'hCAFE_F00D with ack_o; access_cnt_o = 2.
- Byte lanes: after writing 32'h1122_3344 to BASE+0x4, write 32'hAABB_CCDD with sel = 4'b0101 -> read returns 32'h11BB_33DD.
- Miss: write to BASE + 4*DEPTH_WORDS -> acked, memory unchanged. Read of the same address -> 32'h0 with ack.
- Abort: drop cyc_i one cycle after accepting a write to BASE+0x8 -> no ack_o; BASE+0x8 still reads 0; access_cnt_o unchanged.
- Back-to-back with WAIT_STATES = 0, stb_i held high for 3 reads -> ack_o pulses every 2nd cycle, never consecutive. Counter wrap: preload via 65536 transfers -> access_cnt_o = 0.
- Async reset asserted during WAIT and off-clock-edge -> ack_o, busy_o and access_cnt_o go to 0 immediately; a subsequent read of any word returns 0.
